// File: rtl/mbs_int_arbiter.sv
// mbs_int_arbiter: interrupt source arbiter in front of the CPU core.
// Synchronises the peripheral request lines, keeps a pending vector, picks the
// lowest-index unmasked pending line and drives its code onto int_vec. The
// core's int_able output is the handshake: falling = ISR entered, rising = ISR left.
module mbs_int_arbiter #(
   parameter int                 N_IRQ     = 8,
   parameter int                 VEC_WIDTH = 4,
   parameter logic [N_IRQ-1:0]   EDGE_MASK = {N_IRQ{1'b1}},
   parameter int                 TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IRQ-1:0]     irq,
   input  logic [N_IRQ-1:0]     irq_mask,
   input  logic                 int_able,
   output logic [VEC_WIDTH-1:0] int_vec,
   output logic [N_IRQ-1:0]     pending,
   output logic [VEC_WIDTH-1:0] in_service,
   output logic                 busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_SERVICE
   } state_t;

   state_t               state;
   state_t               next_state;

   logic [N_IRQ-1:0]     sync1;
   logic [N_IRQ-1:0]     sync2;
   logic [N_IRQ-1:0]     hist;
   logic [N_IRQ-1:0]     rise;
   logic [N_IRQ-1:0]     eligible;
   logic [N_IRQ-1:0]     clr_vec;

   logic [VEC_WIDTH-1:0] sel_code;
   logic [N_IRQ-1:0]     sel_oh;
   logic [VEC_WIDTH-1:0] win_code;
   logic [N_IRQ-1:0]     win_oh;

   logic [CNT_W-1:0]     cnt;
   logic                 load_cnt;

   logic                 int_able_q;
   logic                 accept;
   logic                 release_evt;

   assign rise        = sync2 & ~hist;
   assign eligible    = pending & irq_mask;
   assign accept      = int_able_q & ~int_able;
   assign release_evt = ~int_able_q & int_able;

   // Two-flop synchroniser per line plus a history flop for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= irq;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   // Fixed priority: the lowest eligible index wins; the code presented is index+1
   always_comb begin
      sel_code = '0;
      sel_oh   = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_code = VEC_WIDTH'(i + 1);
            sel_oh   = N_IRQ'(1) << i;
         end
      end
   end

   // Next-state logic; acceptance beats a mask drop, which beats the timeout
   always_comb begin
      next_state = state;
      load_cnt   = 1'b0;
      clr_vec    = '0;
      unique case (state)
         ST_IDLE: begin
            if (int_able && (eligible != '0)) begin
               next_state = ST_ASSERT;
               load_cnt   = 1'b1;
            end
         end
         ST_ASSERT: begin
            if (accept) begin
               next_state = ST_SERVICE;
               clr_vec    = win_oh & EDGE_MASK;
            end else if ((win_oh & irq_mask) == '0) begin
               next_state = ST_IDLE;
            end else if (cnt == '0) begin
               next_state = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (release_evt) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Pending vector: edge lines latch until accepted (a new edge beats the clear), level lines follow the synced input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (((pending & ~clr_vec) | rise) & EDGE_MASK) | (sync2 & ~EDGE_MASK);
      end
   end

   // State register, previous int_able for edge detection, and the busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         int_able_q <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= next_state;
         int_able_q <= int_able;
         busy       <= (next_state != ST_IDLE);
      end
   end

   // Winner is frozen at decision time so int_vec stays stable through ASSERT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_code <= '0;
         win_oh   <= '0;
      end else if (load_cnt) begin
         win_code <= sel_code;
         win_oh   <= sel_oh;
      end
   end

   // Timeout counter: loaded on decision, counts down while waiting for acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load_cnt) begin
         cnt <= CNT_W'(TIMEOUT);
      end else if ((state == ST_ASSERT) && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Output registers: int_vec lags the decision by one cycle, in_service tracks the ISR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_vec    <= '0;
         in_service <= '0;
      end else begin
         int_vec <= ((state == ST_ASSERT) && (next_state == ST_ASSERT)) ? win_code : '0;
         if ((state == ST_ASSERT) && (next_state == ST_SERVICE)) begin
            in_service <= win_code;
         end else if ((state == ST_SERVICE) && (next_state == ST_IDLE)) begin
            in_service <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mbs_int_arbiter.sv
// tb_mbs_int_arbiter: directed bench for the interrupt arbiter with
// hand-computed expectations, checked by immediate assertions.
module tb_mbs_int_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] irq;
   logic [7:0] irq_mask;
   logic       int_able;
   logic [3:0] int_vec;
   logic [7:0] pending;
   logic [3:0] in_service;
   logic       busy;

   int errors = 0;
   int checks = 0;

   mbs_int_arbiter #(
      .N_IRQ     (8),
      .VEC_WIDTH (4),
      .EDGE_MASK (8'hFF),
      .TIMEOUT   (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq        (irq),
      .irq_mask   (irq_mask),
      .int_able   (int_able),
      .int_vec    (int_vec),
      .pending    (pending),
      .in_service (in_service),
      .busy       (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic [7:0] irq_v, input logic [7:0] mask_v, input logic able_v);
      irq      = irq_v;
      irq_mask = mask_v;
      int_able = able_v;
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Linear directed sequence; each tick() lands 1ns after a rising edge
   initial begin
      rst_n = 1'b0;
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(2);
      checkOutput("rst_int_vec", 32'(int_vec), 32'h0);
      checkOutput("rst_pending", 32'(pending), 32'h0);
      checkOutput("rst_in_service", 32'(in_service), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick(2);
      checkOutput("idle_int_vec", 32'(int_vec), 32'h0);

      // Single edge line 2, one-cycle pulse
      applyStimulus(8'h04, 8'hFF, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(2);
      checkOutput("single_pending_e3", 32'(pending), 32'h04);
      checkOutput("single_vec_e3", 32'(int_vec), 32'h0);
      tick(1);
      checkOutput("single_busy_e4", 32'(busy), 32'h1);
      checkOutput("single_vec_e4", 32'(int_vec), 32'h0);
      tick(1);
      checkOutput("single_vec_e5", 32'(int_vec), 32'h3);
      applyStimulus(8'h00, 8'hFF, 1'b0);
      tick(1);
      checkOutput("single_acc_pending", 32'(pending), 32'h00);
      checkOutput("single_acc_in_service", 32'(in_service), 32'h3);
      checkOutput("single_acc_vec", 32'(int_vec), 32'h0);
      checkOutput("single_acc_busy", 32'(busy), 32'h1);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      checkOutput("single_ret_in_service", 32'(in_service), 32'h0);
      checkOutput("single_ret_busy", 32'(busy), 32'h0);

      // Priority: lines 5 and 1 together, line 1 first (edges counted from here)
      applyStimulus(8'h22, 8'hFF, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(2);
      checkOutput("prio_pending", 32'(pending), 32'h22);
      tick(2);
      checkOutput("prio_vec_first", 32'(int_vec), 32'h2);
      applyStimulus(8'h00, 8'hFF, 1'b0);
      tick(1);
      checkOutput("prio_acc_in_service", 32'(in_service), 32'h2);
      checkOutput("prio_acc_pending", 32'(pending), 32'h20);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      checkOutput("prio_ret_busy", 32'(busy), 32'h0);
      checkOutput("prio_ret_vec", 32'(int_vec), 32'h0);
      tick(1);
      checkOutput("prio_idle_gap_vec", 32'(int_vec), 32'h0);
      checkOutput("prio_idle_gap_busy", 32'(busy), 32'h1);
      tick(1);
      checkOutput("prio_vec_second", 32'(int_vec), 32'h6);

      // Timeout: no acceptance, int_vec=6 for 16 cycles then drops and re-asserts
      tick(15);
      checkOutput("tmo_vec_last", 32'(int_vec), 32'h6);
      tick(1);
      checkOutput("tmo_vec_drop", 32'(int_vec), 32'h0);
      checkOutput("tmo_busy_drop", 32'(busy), 32'h0);
      checkOutput("tmo_pending_kept", 32'(pending), 32'h20);
      tick(1);
      checkOutput("tmo_redecide_busy", 32'(busy), 32'h1);
      checkOutput("tmo_redecide_vec", 32'(int_vec), 32'h0);
      tick(1);
      checkOutput("tmo_reassert_vec", 32'(int_vec), 32'h6);

      // Preemption by timeout: line 0 arrives while line 5 is presented
      applyStimulus(8'h01, 8'hFF, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(2);
      checkOutput("pre_pending", 32'(pending), 32'h21);
      checkOutput("pre_vec_held", 32'(int_vec), 32'h6);
      tick(12);
      checkOutput("pre_vec_last", 32'(int_vec), 32'h6);
      tick(1);
      checkOutput("pre_vec_drop", 32'(int_vec), 32'h0);
      tick(1);
      checkOutput("pre_redecide_busy", 32'(busy), 32'h1);
      tick(1);
      checkOutput("pre_vec_line0", 32'(int_vec), 32'h1);
      applyStimulus(8'h00, 8'hFF, 1'b0);
      tick(1);
      checkOutput("pre_acc_in_service", 32'(in_service), 32'h1);
      checkOutput("pre_acc_pending", 32'(pending), 32'h20);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      checkOutput("pre_ret_busy", 32'(busy), 32'h0);
      tick(2);
      checkOutput("pre_vec_line5", 32'(int_vec), 32'h6);
      applyStimulus(8'h00, 8'hFF, 1'b0);
      tick(1);
      checkOutput("pre_acc5_in_service", 32'(in_service), 32'h6);
      checkOutput("pre_acc5_pending", 32'(pending), 32'h00);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      checkOutput("pre_ret5_in_service", 32'(in_service), 32'h0);

      // Mask: line 3 latched while masked, not presented
      applyStimulus(8'h08, 8'hF7, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hF7, 1'b1);
      tick(2);
      checkOutput("mask_pending", 32'(pending), 32'h08);
      tick(2);
      checkOutput("mask_vec", 32'(int_vec), 32'h0);
      checkOutput("mask_busy", 32'(busy), 32'h0);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      checkOutput("unmask_busy", 32'(busy), 32'h1);
      tick(1);
      checkOutput("unmask_vec", 32'(int_vec), 32'h4);

      // Set wins: a new line-3 edge reaches pending in the acceptance cycle
      applyStimulus(8'h08, 8'hFF, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hFF, 1'b0);
      tick(1);
      checkOutput("setwins_pending", 32'(pending), 32'h08);
      checkOutput("setwins_in_service", 32'(in_service), 32'h4);
      checkOutput("setwins_vec", 32'(int_vec), 32'h0);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);
      checkOutput("setwins_ret_in_service", 32'(in_service), 32'h0);
      tick(2);
      checkOutput("setwins_reassert_vec", 32'(int_vec), 32'h4);
      applyStimulus(8'h00, 8'hFF, 1'b0);
      tick(1);
      checkOutput("setwins_acc2_pending", 32'(pending), 32'h00);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(1);

      // Reset mid-operation with int_vec=3 and lines 2 and 6 pending
      applyStimulus(8'h44, 8'hFF, 1'b1);
      tick(1);
      applyStimulus(8'h00, 8'hFF, 1'b1);
      tick(2);
      checkOutput("midrst_pending_before", 32'(pending), 32'h44);
      tick(2);
      checkOutput("midrst_vec_before", 32'(int_vec), 32'h3);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_int_vec", 32'(int_vec), 32'h0);
      checkOutput("midrst_pending", 32'(pending), 32'h00);
      checkOutput("midrst_in_service", 32'(in_service), 32'h0);
      checkOutput("midrst_busy", 32'(busy), 32'h0);
      tick(1);
      rst_n = 1'b1;
      tick(5);
      checkOutput("postrst_vec", 32'(int_vec), 32'h0);
      checkOutput("postrst_busy", 32'(busy), 32'h0);
      checkOutput("postrst_pending", 32'(pending), 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
